// File: rtl/i2s_master_port.sv
// -----------------------------------------------------------------------------
// i2s_master_port
//
// I2S bus master for the audio codec. It runs on the 12 MHz codec master clock
// and divides it down to BCLK and LRCK. Stereo DAC samples are serialised
// MSB-first with the standard I2S one-bit delay. Stereo ADC samples are
// deserialised into parallel words.
//
// Framing: one BCLK period is BCLK_DIV clk cycles, and one frame is
// 2*SLOT_BITS BCLK periods (left slot, then right slot). With the default
// parameters this gives BCLK = 3 MHz, 64 BCLK per frame and fs = 46.875 kHz.
//
// rst_n asserts asynchronously. Its release is expected to be already
// synchronous to clk; the PLL lock logic upstream provides that.
//
// Ports
//   clk          in   codec master clock (PLL clkout0)
//   rst_n        in   asynchronous active-low reset
//   i2s_bclk     out  bit clock to codec
//   i2s_lrck     out  word select, 0 = left slot, 1 = right slot
//   i2s_dout     out  serial DAC data, changes on BCLK falling edge
//   i2s_din      in   serial ADC data, sampled just before BCLK rises
//   tx_left      in   left DAC sample (signed)
//   tx_right     in   right DAC sample (signed)
//   tx_valid     in   TX sample pair offered
//   tx_ready     out  TX holding register empty
//   tx_underrun  out  1-cycle pulse: frame started without a new pair
//   rx_left      out  last captured left ADC sample
//   rx_right     out  last captured right ADC sample
//   rx_valid     out  1-cycle pulse: rx_left/rx_right updated
// -----------------------------------------------------------------------------
module i2s_master_port #(
  parameter int DATA_W    = 16,
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_dout,
  input  logic              i2s_din,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [DIV_W-1:0] RISE_CNT = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FALL_CNT = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_BITS);
  // Slot position of the last right-channel bit. When DATA_W == SLOT_BITS this
  // wraps to position 0 of the following frame.
  localparam logic [BIT_W-1:0] RX_LAST  = BIT_W'((SLOT_BITS + DATA_W) % FRAME_BITS);

  // Timing state
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_bclk;
  logic              r_lrck;
  logic              r_dout;

  // TX state. r_tx_ready doubles as the "holding register empty" flag.
  logic              r_tx_ready;
  logic              r_underrun;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_shadow_l;
  logic [DATA_W-1:0] r_shadow_r;

  // RX state
  logic [DATA_W-1:0] r_rx_sh_l;
  logic [DATA_W-1:0] r_rx_sh_r;
  logic [DATA_W-1:0] r_rx_left;
  logic [DATA_W-1:0] r_rx_right;
  logic              r_rx_valid;

  logic              w_rise;
  logic              w_fall;
  logic [BIT_W-1:0]  w_bit_next;
  logic              w_frame_start;
  logic              w_accept;
  logic              w_rx_done;
  logic [DATA_W-1:0] w_tx_sel_l;
  logic [DATA_W-1:0] w_tx_sel_r;
  logic              w_tx_bit;
  logic [DATA_W-1:0] w_rx_sh_l_next;
  logic [DATA_W-1:0] w_rx_sh_r_next;

  assign w_rise        = (r_div_cnt == RISE_CNT);
  assign w_fall        = (r_div_cnt == FALL_CNT);
  assign w_bit_next    = (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BIT_W'(1);
  assign w_frame_start = w_fall && (r_bit_cnt == LAST_BIT);
  assign w_accept      = tx_valid && r_tx_ready;
  assign w_rx_done     = w_rise && (r_bit_cnt == RX_LAST);

  // Word bit gi sits at slot position DATA_W-gi. TX looks at the bit position
  // that becomes current at the coming falling edge. RX looks at the current
  // position, because din is sampled while that bit is on the wire.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_slot_bit
    localparam logic [BIT_W-1:0] POS_L = BIT_W'(DATA_W - gi);
    localparam logic [BIT_W-1:0] POS_R = BIT_W'((SLOT_BITS + DATA_W - gi) % FRAME_BITS);

    assign w_tx_sel_l[gi] = (w_bit_next == POS_L) && r_shadow_l[gi];
    assign w_tx_sel_r[gi] = (w_bit_next == POS_R) && r_shadow_r[gi];

    assign w_rx_sh_l_next[gi] = (r_bit_cnt == POS_L) ? i2s_din : r_rx_sh_l[gi];
    assign w_rx_sh_r_next[gi] = (r_bit_cnt == POS_R) ? i2s_din : r_rx_sh_r[gi];
  end

  // At most one select bit is set. Positions outside the data field give 0.
  assign w_tx_bit = |{w_tx_sel_l, w_tx_sel_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_lrck     <= 1'b0;
      r_dout     <= 1'b0;
      r_tx_ready <= 1'b1;
      r_underrun <= 1'b0;
      r_hold_l   <= '0;
      r_hold_r   <= '0;
      r_shadow_l <= '0;
      r_shadow_r <= '0;
      r_rx_sh_l  <= '0;
      r_rx_sh_r  <= '0;
      r_rx_left  <= '0;
      r_rx_right <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      r_rx_valid <= 1'b0;
      r_div_cnt  <= w_fall ? '0 : r_div_cnt + DIV_W'(1);

      if (w_rise) begin
        r_bclk    <= 1'b1;
        r_rx_sh_l <= w_rx_sh_l_next;
        r_rx_sh_r <= w_rx_sh_r_next;
        // Take the word including the bit sampled on this same edge.
        if (w_rx_done) begin
          r_rx_left  <= w_rx_sh_l_next;
          r_rx_right <= w_rx_sh_r_next;
          r_rx_valid <= 1'b1;
        end
      end

      if (w_fall) begin
        r_bclk    <= 1'b0;
        r_bit_cnt <= w_bit_next;
        r_lrck    <= (w_bit_next >= SLOT_B);
        r_dout    <= w_tx_bit;
      end

      // Frame start decides on the holding state before any accept in the
      // same cycle. Accept can only happen while holding is empty, so an
      // accept here always lands in holding and serves the next frame.
      if (w_frame_start) begin
        if (!r_tx_ready) begin
          r_shadow_l <= r_hold_l;
          r_shadow_r <= r_hold_r;
          r_tx_ready <= 1'b1;
        end else begin
          r_underrun <= 1'b1;
        end
      end

      if (w_accept) begin
        r_hold_l   <= tx_left;
        r_hold_r   <= tx_right;
        r_tx_ready <= 1'b0;
      end
    end
  end

  assign i2s_bclk    = r_bclk;
  assign i2s_lrck    = r_lrck;
  assign i2s_dout    = r_dout;
  assign tx_ready    = r_tx_ready;
  assign tx_underrun = r_underrun;
  assign rx_left     = r_rx_left;
  assign rx_right    = r_rx_right;
  assign rx_valid    = r_rx_valid;

endmodule

// File: doc/i2s_master_port.md
Name: i2s_master_port

Overview:
- Audio codec serial port clocked by the 12 MHz PLL output, used as codec MCLK. Sits directly downstream of the PLL.
- Generates I2S BCLK and LRCK as bus master.
- Serializes stereo DAC samples from the pitch-shift datapath.
- Deserializes stereo ADC samples into parallel words for that datapath.
- Default framing: BCLK = 3 MHz, 64 BCLK per frame, fs = 46.875 kHz.

Parameters:
- DATA_W, 16: sample width in bits, MSB-first, 1..SLOT_BITS.
- BCLK_DIV, 4: clk cycles per BCLK period; even, >=2.
- SLOT_BITS, 32: BCLK cycles per channel slot; frame = 2*SLOT_BITS BCLK.

Ports:
- clk  in  1  12 MHz codec master clock (PLL clkout0)
- rst_n  in  1  asynchronous active-low reset
- i2s_bclk  out  1  bit clock to codec
- i2s_lrck  out  1  word select; 0 = left, 1 = right
- i2s_dout  out  1  serial DAC data to codec
- i2s_din  in  1  serial ADC data from codec
- tx_left  in  DATA_W  left DAC sample, signed
- tx_right  in  DATA_W  right DAC sample, signed
- tx_valid  in  1  TX sample pair offered
- tx_ready  out  1  TX holding register empty
- tx_underrun  out  1  one-cycle pulse: frame started with no new sample
- rx_left  out  DATA_W  last captured left ADC sample
- rx_right  out  DATA_W  last captured right ADC sample
- rx_valid  out  1  one-cycle pulse: rx_left/rx_right updated

Behaviour:
- Reset (async assert, sync release): div_cnt=0, bit_cnt=0. i2s_bclk=0, i2s_lrck=0, i2s_dout=0. rx_left=0, rx_right=0, rx_valid=0. tx_ready=1, tx_underrun=0. TX shift/shadow registers=0. Holding register empty. Reset mid-frame aborts everything; no partial rx_valid is issued.
- div_cnt counts 0..BCLK_DIV-1 and wraps.
- Rise event: div_cnt==BCLK_DIV/2-1. On the next edge i2s_bclk<=1.
- Fall event: div_cnt==BCLK_DIV-1. On the next edge i2s_bclk<=0, and bit_cnt increments modulo 2*SLOT_BITS.
- i2s_lrck updates on fall events only: 0 for new bit_cnt in 0..SLOT_BITS-1, 1 otherwise. Changes coincide with BCLK falling edge.
- All outputs are registered.
- Standard I2S one-bit delay: left MSB is driven at bit_cnt=1; right MSB at bit_cnt=SLOT_BITS+1.
- TX path:
  - Holding register accepts on tx_valid && tx_ready. tx_ready drops the next cycle.
  - Frame start is the fall event that wraps bit_cnt to 0.
  - If holding is full at frame start (contents before any same-cycle accept), load the shadow registers, clear holding, and raise tx_ready.
  - If holding is empty, the shadow keeps the previous pair (repeat) and tx_underrun pulses for 1 cycle.
  - An accept in the same cycle as frame start is stored in holding and used at the next frame.
- i2s_dout on each fall event: shadow_left[DATA_W-n] for new bit_cnt n in 1..DATA_W; shadow_right[DATA_W-m] for m = n-SLOT_BITS in 1..DATA_W; 0 elsewhere.
- First frame after reset transmits zeros; first load happens at the first wrap.
- RX path:
  - i2s_din is sampled on rise events into a left or right shift register for the same slot bit positions as TX.
  - After the rise event at bit_cnt==SLOT_BITS+DATA_W: on the next edge, rx_left and rx_right take the assembled words and rx_valid=1 for exactly 1 cycle.
  - rx_left/rx_right hold their values between updates.
- Bits past DATA_W in a slot are ignored on RX and driven 0 on TX.

Test Plan:
- Clocking: release reset, defaults -> i2s_bclk period 4 clk at 50% duty; i2s_lrck period 256 clk; lrck low for the first 128 clk; lrck edges coincide with bclk falling edges.
- TX framing: accept L=16'hA5C3, R=16'h8001 in frame 0 -> frame 1 dout bits 1..16 = A5C3 MSB-first, bits 17..32 = 0, bits 33..48 = 8001; tx_ready returns 1 at frame-1 start.
- RX loopback: din tied to dout with the same stimulus -> rx_valid pulses once in frame 1, after the rise at bit 48, with rx_left=16'hA5C3, rx_right=16'h8001; no other rx_valid that frame.
- Underrun: no tx_valid during frame 1 -> tx_underrun 1-cycle pulse at frame-2 start; frame 2 dout repeats A5C3/8001.
- Backpressure: tx_valid held with pairs P1, P2 back-to-back -> P1 accepted; tx_ready=0 until the next frame start; P2 accepted the cycle after; P1 and P2 are transmitted in consecutive frames with no underrun.
- Reset mid-frame: rst_n low at bit_cnt=40 -> all outputs at reset values immediately, no rx_valid; after release, timing restarts as in the Clocking scenario.
